// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: emits i_count pulses of high_len active cycles
// followed by low_len idle cycles, with start/abort control and edge/completion strobes.
module pulse_train_gen #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_high_len,
    input  logic [WIDTH-1:0] i_low_len,
    input  logic [WIDTH-1:0] i_count,
    output logic             o_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rise,
    output logic             o_fall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam logic             ACTIVE_LEVEL = ~IDLE_LEVEL;
    localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_high_len,  w_high_len_next;
    logic [WIDTH-1:0] r_low_len,   w_low_len_next;
    logic [WIDTH-1:0] r_count,     w_count_next;
    logic [WIDTH-1:0] r_phase_cnt, w_phase_cnt_next;
    logic [WIDTH-1:0] r_pulse_cnt, w_pulse_cnt_next;

    logic r_out,  w_out_next;
    logic r_busy, w_busy_next;
    logic r_done, w_done_next;
    logic r_rise, w_rise_next;
    logic r_fall, w_fall_next;

    logic w_count_zero;
    logic w_high_end;
    logic w_low_end;
    logic w_last_pulse;

    // A zero length still occupies one cycle so every phase is observable.
    function automatic logic [WIDTH-1:0] min_one(input logic [WIDTH-1:0] len);
        return (len == '0) ? ONE : len;
    endfunction

    // Phase counter holds the 1-based cycle number within the current phase,
    // pulse counter the 1-based index of the current pulse; neither can wrap.
    assign w_count_zero = (i_count == '0);
    assign w_high_end   = (r_phase_cnt == r_high_len);
    assign w_low_end    = (r_phase_cnt == r_low_len);
    assign w_last_pulse = (r_pulse_cnt == r_count);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_high_len  <= '0;
            r_low_len   <= '0;
            r_count     <= '0;
            r_phase_cnt <= '0;
            r_pulse_cnt <= '0;
            r_out       <= IDLE_LEVEL;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_high_len  <= w_high_len_next;
            r_low_len   <= w_low_len_next;
            r_count     <= w_count_next;
            r_phase_cnt <= w_phase_cnt_next;
            r_pulse_cnt <= w_pulse_cnt_next;
            r_out       <= w_out_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_rise      <= w_rise_next;
            r_fall      <= w_fall_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start && !w_count_zero) begin
                    w_state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else if (w_high_end) begin
                    w_state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else if (w_low_end) begin
                    w_state_next = w_last_pulse ? S_IDLE : S_HIGH;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Computes the next value of every registered output and counter, so the
    // ports themselves come straight from flops.
    always_comb begin
        w_high_len_next  = r_high_len;
        w_low_len_next   = r_low_len;
        w_count_next     = r_count;
        w_phase_cnt_next = r_phase_cnt;
        w_pulse_cnt_next = r_pulse_cnt;
        w_out_next       = r_out;
        w_busy_next      = r_busy;
        w_done_next      = 1'b0;
        w_rise_next      = 1'b0;
        w_fall_next      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_out_next  = IDLE_LEVEL;
                w_busy_next = 1'b0;
                if (i_start) begin
                    w_high_len_next = min_one(i_high_len);
                    w_low_len_next  = min_one(i_low_len);
                    w_count_next    = i_count;
                    if (w_count_zero) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_phase_cnt_next = ONE;
                        w_pulse_cnt_next = ONE;
                        w_out_next       = ACTIVE_LEVEL;
                        w_busy_next      = 1'b1;
                        w_rise_next      = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (i_abort) begin
                    w_phase_cnt_next = '0;
                    w_pulse_cnt_next = '0;
                    w_out_next       = IDLE_LEVEL;
                    w_busy_next      = 1'b0;
                    w_fall_next      = 1'b1;
                end else if (w_high_end) begin
                    w_phase_cnt_next = ONE;
                    w_out_next       = IDLE_LEVEL;
                    w_fall_next      = 1'b1;
                end else begin
                    w_phase_cnt_next = r_phase_cnt + ONE;
                end
            end
            S_LOW: begin
                if (i_abort) begin
                    w_phase_cnt_next = '0;
                    w_pulse_cnt_next = '0;
                    w_out_next       = IDLE_LEVEL;
                    w_busy_next      = 1'b0;
                end else if (w_low_end) begin
                    if (w_last_pulse) begin
                        w_phase_cnt_next = '0;
                        w_pulse_cnt_next = '0;
                        w_busy_next      = 1'b0;
                        w_done_next      = 1'b1;
                    end else begin
                        w_phase_cnt_next = ONE;
                        w_pulse_cnt_next = r_pulse_cnt + ONE;
                        w_out_next       = ACTIVE_LEVEL;
                        w_rise_next      = 1'b1;
                    end
                end else begin
                    w_phase_cnt_next = r_phase_cnt + ONE;
                end
            end
            default: begin
                w_out_next  = IDLE_LEVEL;
                w_busy_next = 1'b0;
            end
        endcase
    end

    assign o_out  = r_out;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: one instance per idle polarity, driven in lockstep,
// waveforms captured per cycle and compared against hand-derived bit patterns.
module tb_pulse_train_gen;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         start    = 1'b0;
    logic         abort    = 1'b0;
    logic [W-1:0] high_len = '0;
    logic [W-1:0] low_len  = '0;
    logic [W-1:0] count    = '0;

    logic out0, busy0, done0, rise0, fall0;
    logic out1, busy1, done1, rise1, fall1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] wv_out, wv_rise, wv_fall, wv_busy, wv_done;
    logic [63:0] wv_out1, wv_rise1, wv_fall1;
    int rise_cnt, fall_cnt, busy_cnt, done_cnt, done_at;

    // Falling-edge detector on the inverted-polarity output.
    logic fe_prev = 1'b1;
    int   fe_cnt  = 0;
    int   fe_base;

    pulse_train_gen #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_high_len(high_len), .i_low_len(low_len), .i_count(count),
        .o_out(out0), .o_busy(busy0), .o_done(done0), .o_rise(rise0), .o_fall(fall0)
    );

    pulse_train_gen #(.WIDTH(W), .IDLE_LEVEL(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_high_len(high_len), .i_low_len(low_len), .i_count(count),
        .o_out(out1), .o_busy(busy1), .o_done(done1), .o_rise(rise1), .o_fall(fall1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        fe_prev <= out1;
        if (fe_prev && !out1) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("pass %-22s got %0h", tag, got);
        end else begin
            $display("FAIL %-22s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Enter at a negedge; starts a train, then records ncyc cycles. start_mask bit k
    // raises i_start (with the alt operands) during cycle k, abort_at raises i_abort.
    task automatic capture(input int hl, input int ll, input int cnt, input int ncyc,
                           input int abort_at, input logic [63:0] start_mask,
                           input int ahl, input int all, input int acnt);
        wv_out = '0; wv_rise = '0; wv_fall = '0; wv_busy = '0; wv_done = '0;
        wv_out1 = '0; wv_rise1 = '0; wv_fall1 = '0;
        rise_cnt = 0; fall_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = 0;
        high_len = W'(hl); low_len = W'(ll); count = W'(cnt);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        high_len = W'(ahl); low_len = W'(all); count = W'(acnt);
        for (int k = 1; k <= ncyc; k++) begin
            wv_out   = {wv_out[62:0],   out0};
            wv_rise  = {wv_rise[62:0],  rise0};
            wv_fall  = {wv_fall[62:0],  fall0};
            wv_busy  = {wv_busy[62:0],  busy0};
            wv_done  = {wv_done[62:0],  done0};
            wv_out1  = {wv_out1[62:0],  out1};
            wv_rise1 = {wv_rise1[62:0], rise1};
            wv_fall1 = {wv_fall1[62:0], fall1};
            rise_cnt += int'(rise0);
            fall_cnt += int'(fall0);
            busy_cnt += int'(busy0);
            done_cnt += int'(done0);
            if (done0 && done_at == 0) done_at = k;
            start = (k < 64) ? start_mask[k] : 1'b0;
            abort = (k == abort_at);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_async_outs", {out0, busy0, done0, rise0, fall0}, 64'h0);
        check("reset_async_out_inv", out1, 64'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", {out0, busy0, done0, rise0, fall0}, 64'h0);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_idle", {out0, busy0, done0, rise0, fall0}, 64'h0);
        @(negedge clk);

        capture(2, 3, 3, 16, 0, 64'h0, 7, 7, 7);
        check("basic_out",  wv_out,  64'hC630);
        check("basic_rise", wv_rise, 64'h8420);
        check("basic_fall", wv_fall, 64'h2108);
        check("basic_busy", wv_busy, 64'hFFFE);
        check("basic_done", wv_done, 64'h0001);

        capture(0, 0, 4, 9, 0, 64'h0, 0, 0, 0);
        check("zero_len_out",  wv_out,  64'h154);
        check("zero_len_rise", wv_rise, 64'h154);
        check("zero_len_fall", wv_fall, 64'h0AA);
        check("zero_len_busy", wv_busy, 64'h1FE);
        check("zero_len_done", wv_done, 64'h001);

        capture(3, 3, 0, 3, 0, 64'h0, 0, 0, 0);
        check("zero_cnt_out",  wv_out,  64'h0);
        check("zero_cnt_busy", wv_busy, 64'h0);
        check("zero_cnt_done", wv_done, 64'h4);
        check("zero_cnt_rise", wv_rise, 64'h0);

        capture(4, 4, 2, 14, 10, 64'h0, 4, 4, 2);
        check("abort_out",  wv_out,  64'h3C30);
        check("abort_rise", wv_rise, 64'h2020);
        check("abort_fall", wv_fall, 64'h0208);
        check("abort_busy", wv_busy, 64'h3FF0);
        check("abort_done", wv_done, 64'h0);

        capture(1, 1, 3, 4, 2, 64'h0, 1, 1, 3);
        check("abort_prio_out",  wv_out,  64'h8);
        check("abort_prio_rise", wv_rise, 64'h8);
        check("abort_prio_fall", wv_fall, 64'h4);
        check("abort_prio_busy", wv_busy, 64'hC);
        check("abort_prio_done", wv_done, 64'h0);

        capture(1, 1, 2, 9, 0, 64'h24, 2, 1, 1);
        check("restart_out",  wv_out,  64'h14C);
        check("restart_rise", wv_rise, 64'h148);
        check("restart_fall", wv_fall, 64'h0A2);
        check("restart_busy", wv_busy, 64'h1EE);
        check("restart_done", wv_done, 64'h011);

        fe_base = fe_cnt;
        capture(1, 2, 2, 7, 0, 64'h0, 0, 0, 0);
        @(negedge clk);
        check("inv_ref_out",   wv_out,   64'h48);
        check("inv_out",       wv_out1,  64'h37);
        check("inv_rise",      wv_rise1, 64'h48);
        check("inv_fall",      wv_fall1, 64'h24);
        check("inv_fall_edges", fe_cnt - fe_base, 64'd2);

        capture(0, 0, 255, 512, 0, 64'h0, 0, 0, 0);
        check("max_cnt_rises",   rise_cnt, 64'd255);
        check("max_cnt_falls",   fall_cnt, 64'd255);
        check("max_cnt_busy",    busy_cnt, 64'd510);
        check("max_cnt_done_at", done_at,  64'd511);
        check("max_cnt_dones",   done_cnt, 64'd1);

        capture(3, 3, 2, 4, 0, 64'h0, 3, 3, 2);
        check("pre_reset_out",  wv_out,  64'hE);
        check("pre_reset_busy", wv_busy, 64'hF);
        #2 rst_n = 1'b0;
        #1;
        check("midtrain_reset_outs", {out0, busy0, done0, rise0, fall0}, 64'h0);
        check("midtrain_reset_inv",  out1, 64'h1);
        @(negedge clk);
        @(negedge clk);
        check("no_done_in_reset", {busy0, done0}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        capture(1, 1, 1, 3, 0, 64'h0, 0, 0, 0);
        check("post_reset_out",  wv_out,  64'h4);
        check("post_reset_busy", wv_busy, 64'h6);
        check("post_reset_done", wv_done, 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
